spi_reg_loader: RTL and testbench

Parametrised multi-lane serial register loader. It captures `LANES` bits per clock from a nibble-style serial bus into one of `NREG` target registers of `REGW` bits each. Incoming data is staged in a shadow buffer and committed atomically only when a frame completes, so a target register never holds partial data. It sits between the chip's dedicated input pins and the compute datapath: weights, activations and similar banks all load through one shared instance.

---
 rtl/spi_reg_loader_pkg.sv | 18 +
 rtl/spi_reg_loader_if.sv | 14 +
 rtl/spi_reg_loader_shifter.sv | 50 +++++
 rtl/spi_reg_loader.sv | 153 +++++++++++++++
 tb/tb_spi_reg_loader.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_loader_pkg.sv
// Shared types for the serial register loader: FSM state encoding and
// the beat-counter width helper used by the top level and the shifter.
package spi_loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WAIT
   } state_e;

   // Width of a counter that indexes the beats of one frame (min 1).
   function automatic int cnt_width(input int regw, input int lanes);
      int beats;
      beats = regw / lanes;
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/spi_reg_loader_if.sv
// Serial load bus: frame enable, target select, data lanes, readback lane.
// master drives cs_n/sel/din and reads dout; slave is the loader side.
interface spi_reg_loader_if #(
   parameter int LANES = 4,
   parameter int SELW  = 1
);
   logic             cs_n;
   logic [SELW-1:0]  sel;
   logic [LANES-1:0] din;
   logic [LANES-1:0] dout;

   modport master (output cs_n, sel, din, input dout);
   modport slave  (input cs_n, sel, din, output dout);
endinterface

// File: rtl/spi_reg_loader_shifter.sv
// spi_shadow_shifter: shadow buffer, beat counter and last-beat flag.
// Ports: clk, rst_n, first/shift/flush controls, din in;
//        shadow_nxt (shifted value incl. din), count, last out.
module spi_shadow_shifter
   import spi_loader_pkg::*;
#(
   parameter  int LANES = 4,
   parameter  int REGW  = 128,
   localparam int BEATS = REGW / LANES,
   localparam int CW    = cnt_width(REGW, LANES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             first,
   input  logic             shift,
   input  logic             flush,
   input  logic [LANES-1:0] din,
   output logic [REGW-1:0]  shadow_nxt,
   output logic [CW-1:0]    count,
   output logic             last
);

   logic [REGW-1:0] shadow_q;
   logic [CW-1:0]   count_q;

   // The commit value includes the beat being captured on this edge.
   assign shadow_nxt = {shadow_q[REGW-LANES-1:0], din};
   assign count      = count_q;
   assign last       = (count_q == CW'(BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         count_q  <= '0;
      end else begin
         if (first || shift)
            shadow_q <= shadow_nxt;
         else if (flush)
            shadow_q <= '0;

         if (flush)
            count_q <= '0;
         else if (first)
            count_q <= CW'(1);
         else if (shift)
            count_q <= count_q + CW'(1);
      end
   end

endmodule

// File: rtl/spi_reg_loader.sv
// spi_reg_loader: multi-lane serial loader into NREG registers with
// atomic commit. Ports: clk, rst_n, bus (cs_n/sel/din/dout), clr,
// reg_flat, busy, done, err. Optional: SPI_LOADER_READBACK_EN.
module spi_reg_loader
   import spi_loader_pkg::*;
#(
   parameter  int LANES = 4,
   parameter  int REGW  = 128,
   parameter  int NREG  = 2,
   localparam int SELW  = (NREG > 1) ? $clog2(NREG) : 1,
   localparam int CW    = cnt_width(REGW, LANES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_reg_loader_if.slave      bus,
   input  logic [NREG-1:0]      clr,
   output logic [NREG*REGW-1:0] reg_flat,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   state_e          state_q, state_d;
   logic [SELW-1:0] sel_q;
   logic [REGW-1:0] regs [NREG];
   logic [REGW-1:0] shadow_nxt;
   logic [CW-1:0]   cnt;
   logic            last;
   logic            first, shift, flush, commit, abort;
   logic            sel_ok;

   spi_shadow_shifter #(
      .LANES (LANES),
      .REGW  (REGW)
   ) u_shift (
      .clk        (clk),
      .rst_n      (rst_n),
      .first      (first),
      .shift      (shift),
      .flush      (flush),
      .din        (bus.din),
      .shadow_nxt (shadow_nxt),
      .count      (cnt),
      .last       (last)
   );

   assign sel_ok = (int'(sel_q) < NREG);
   assign busy   = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      first   = 1'b0;
      shift   = 1'b0;
      flush   = 1'b0;
      commit  = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!bus.cs_n) begin
               first   = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!bus.cs_n) begin
               shift = 1'b1;
               if (last) begin
                  commit  = 1'b1;
                  flush   = 1'b1;
                  state_d = WAIT;
               end
            end else begin
               abort   = 1'b1;
               flush   = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (bus.cs_n)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (first)
            sel_q <= bus.sel;
         done <= commit && sel_ok;
         err  <= (commit && !sel_ok) || abort;
      end
   end

   // Clear has priority over a commit to the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (clr[i])
               regs[i] <= '0;
            else if (commit && sel_ok && int'(sel_q) == i)
               regs[i] <= shadow_nxt;
         end
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign reg_flat[g*REGW +: REGW] = regs[g];
   end

`ifdef SPI_LOADER_READBACK_EN
   logic [SELW-1:0] rd_sel;
   logic            rd_en;
   logic [REGW-1:0] rd_word;
   logic [LANES-1:0] dout_c;

   // Beat k presents slice k of the old value; count is 0 in IDLE,
   // so the first slice comes straight from the live sel input.
   always_comb begin
      rd_sel  = '0;
      rd_en   = 1'b0;
      rd_word = '0;
      dout_c  = '0;
      if (state_q == IDLE && !bus.cs_n) begin
         rd_sel = bus.sel;
         rd_en  = 1'b1;
      end else if (state_q == SHIFT) begin
         rd_sel = sel_q;
         rd_en  = 1'b1;
      end
      if (rd_en && int'(rd_sel) < NREG) begin
         rd_word = regs[rd_sel] << (int'(cnt) * LANES);
         dout_c  = rd_word[REGW-1 -: LANES];
      end
   end

   assign bus.dout = dout_c;
`else
   logic unused_cnt;
   assign unused_cnt = ^cnt;
   assign bus.dout   = '0;
`endif

endmodule

// File: tb/tb_spi_reg_loader.sv
// Directed bench for spi_reg_loader (LANES=4, REGW=32): main DUT with
// NREG=2 plus an NREG=3 copy that can see an out-of-range select.
module tb_spi_reg_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs_n;
   logic [1:0]  sel;
   logic [3:0]  din;
   logic [1:0]  clr;
   logic [2:0]  clr3;

   logic [63:0] reg_flat;
   logic        busy, done, err;
   logic [95:0] reg_flat3;
   logic        busy3, done3, err3;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0, err_cnt = 0, done3_cnt = 0, err3_cnt = 0;
   int both_cnt = 0;

   always #5 clk = ~clk;

   spi_reg_loader_if #(.LANES(4), .SELW(1)) bus ();
   spi_reg_loader_if #(.LANES(4), .SELW(2)) bus3 ();

   assign bus.cs_n  = cs_n;
   assign bus.sel   = sel[0];
   assign bus.din   = din;
   assign bus3.cs_n = cs_n;
   assign bus3.sel  = sel;
   assign bus3.din  = din;
   assign clr3      = {1'b0, clr};

   spi_reg_loader #(.LANES(4), .REGW(32), .NREG(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .clr      (clr),
      .reg_flat (reg_flat),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   spi_reg_loader #(.LANES(4), .REGW(32), .NREG(3)) dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus3),
      .clr      (clr3),
      .reg_flat (reg_flat3),
      .busy     (busy3),
      .done     (done3),
      .err      (err3)
   );

   always @(negedge clk) begin
      if (done)  done_cnt  <= done_cnt + 1;
      if (err)   err_cnt   <= err_cnt + 1;
      if (done3) done3_cnt <= done3_cnt + 1;
      if (err3)  err3_cnt  <= err3_cnt + 1;
      if ((done && err) || (done3 && err3))
         both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [95:0] obs,
                      input logic [95:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // nlow cycles of cs_n low (beats beyond 8 carry 0); cl is applied
   // on the edge capturing beat 8; rb collects dout per low cycle.
   task automatic frame(input logic [1:0] s, input logic [31:0] d,
                        input int nlow, input logic [1:0] cl,
                        output logic [31:0] rb);
      logic [31:0] sh;
      sh = d;
      rb = '0;
      for (int k = 0; k < nlow; k++) begin
         @(negedge clk);
         cs_n = 1'b0;
         sel  = s;
         din  = sh[31:28];
         sh   = sh << 4;
         clr  = (k == 7) ? cl : 2'b00;
         #1 rb = {rb[27:0], bus.dout};
      end
      @(negedge clk);
      cs_n = 1'b1;
      clr  = 2'b00;
      din  = 4'h0;
      repeat (2) @(negedge clk);
      #2;
   endtask

   initial begin
      logic [31:0] rb;
      int d0, e0, d3, e3;

      rst_n = 1'b0;
      cs_n  = 1'b1;
      sel   = 2'b00;
      din   = 4'h0;
      clr   = 2'b00;
      repeat (2) @(negedge clk);
      chk("rst_reg", {32'h0, reg_flat}, 96'h0);
      chk("rst_busy", {95'h0, busy}, 96'h0);
      chk("rst_done", {95'h0, done}, 96'h0);
      chk("rst_err", {95'h0, err}, 96'h0);
      chk("rst_dout", {92'h0, bus.dout}, 96'h0);
      chk("rst_dout3", {92'h0, bus3.dout}, 96'h0);
      rst_n = 1'b1;

      frame(2'd0, 32'hA5A5A5A5, 8, 2'b00, rb);
      chk("pre_load", {32'h0, reg_flat}, {64'h0, 32'hA5A5A5A5});

      e0 = err_cnt;
      @(negedge clk);
      cs_n = 1'b0;
      sel  = 2'd0;
      din  = 4'h1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_reg", {32'h0, reg_flat}, 96'h0);
      chk("midrst_busy", {95'h0, busy}, 96'h0);
      repeat (2) @(negedge clk);
      cs_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      chk("midrst_noerr", 96'(err_cnt - e0), 96'd0);

      d0 = done_cnt;
      frame(2'd0, 32'h12345678, 8, 2'b00, rb);
      chk("load0", {32'h0, reg_flat}, {64'h0, 32'h12345678});
      chk("load0_done", 96'(done_cnt - d0), 96'd1);

      d0 = done_cnt;
      e0 = err_cnt;
      frame(2'd1, 32'hDEADBEEF, 8, 2'b00, rb);
      chk("load1", {32'h0, reg_flat}, {32'h0, 64'hDEADBEEF_12345678});
      chk("load1_done", 96'(done_cnt - d0), 96'd1);
      chk("load1_err", 96'(err_cnt - e0), 96'd0);

      frame(2'd0, 32'hCAFEF00D, 8, 2'b00, rb);
      d0 = done_cnt;
      e0 = err_cnt;
      frame(2'd0, 32'hFFFFFFFF, 5, 2'b00, rb);
      chk("abort_err", 96'(err_cnt - e0), 96'd1);
      chk("abort_done", 96'(done_cnt - d0), 96'd0);
      chk("abort_reg", {32'h0, reg_flat}, {32'h0, 64'hDEADBEEF_CAFEF00D});
      chk("abort_busy", {95'h0, busy}, 96'h0);

      frame(2'd1, 32'h0BADF00D, 8, 2'b00, rb);
`ifdef SPI_LOADER_READBACK_EN
      chk("readback", {64'h0, rb}, {64'h0, 32'hDEADBEEF});
`else
      chk("readback_off", {64'h0, rb}, 96'h0);
`endif
      chk("rb_load", {32'h0, reg_flat}, {32'h0, 64'h0BADF00D_CAFEF00D});

      d0 = done_cnt;
      frame(2'd1, 32'h11111111, 8, 2'b10, rb);
      chk("clr_win", {32'h0, reg_flat}, {32'h0, 64'h00000000_CAFEF00D});
      chk("clr_done", 96'(done_cnt - d0), 96'd1);

      frame(2'd1, 32'h55AA55AA, 8, 2'b00, rb);
      @(negedge clk);
      clr = 2'b01;
      @(negedge clk);
      clr = 2'b00;
      #2;
      chk("clr0_only", {32'h0, reg_flat}, {32'h0, 64'h55AA55AA_00000000});

      d0 = done_cnt;
      e0 = err_cnt;
      frame(2'd0, 32'h87654321, 12, 2'b00, rb);
      chk("hold_done", 96'(done_cnt - d0), 96'd1);
      chk("hold_err", 96'(err_cnt - e0), 96'd0);
      chk("hold_reg", {32'h0, reg_flat}, {32'h0, 64'h55AA55AA_87654321});

      d3 = done3_cnt;
      e3 = err3_cnt;
      frame(2'd3, 32'h99999999, 8, 2'b00, rb);
      chk("oor_err", 96'(err3_cnt - e3), 96'd1);
      chk("oor_done", 96'(done3_cnt - d3), 96'd0);
      chk("oor_regs", reg_flat3,
          {32'h00000000, 32'h55AA55AA, 32'h87654321});
      chk("oor_busy", {95'h0, busy3}, 96'h0);
      chk("main_sel1", {32'h0, reg_flat}, {32'h0, 64'h99999999_87654321});
      chk("no_overlap", 96'(both_cnt), 96'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
